// File: rtl/bit2_adder_seq_if.sv
// Operand request and result response handshakes between producers and the adder sequencer.
interface bit2_adder_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                  input  in_ready, out_valid, out_sum, out_cout);
  modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                  output in_ready, out_valid, out_sum, out_cout);
endinterface

// File: rtl/bit2_adder_seq.sv
// Runs a WIDTH-bit add as NSLICE 2-bit slices through a shared pipelined 2-bit adder core,
// rippling each slice's carry into the next and returning the assembled sum.
module bit2_adder_seq #(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  bit2_adder_seq_if.slave  bus,
  output logic             busy,
  output logic             add_a1,
  output logic             add_b1,
  output logic             add_a2,
  output logic             add_b2,
  output logic             add_cin,
  input  logic             add_s1,
  input  logic             add_s2,
  input  logic             add_cout
);
  localparam int NSLICE = WIDTH / 2;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int WW     = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum, r_out_sum;
  logic             r_out_valid, r_out_cout;
  logic [IW-1:0]    r_idx;
  logic [WW-1:0]    r_wait;
  logic             r_add_a1, r_add_b1, r_add_a2, r_add_b2, r_add_cin;

  logic [IW-1:0]    w_idx_inc;
  logic [WIDTH-1:0] w_a_sh, w_b_sh, w_sum_nxt;
  logic             w_last;

  assign w_idx_inc = r_idx + IW'(1);
  assign w_a_sh    = r_a >> {w_idx_inc, 1'b0};
  assign w_b_sh    = r_b >> {w_idx_inc, 1'b0};
  assign w_sum_nxt = (r_sum & ~(WIDTH'(3) << {r_idx, 1'b0}))
                   | (WIDTH'({add_s2, add_s1}) << {r_idx, 1'b0});
  assign w_last    = (r_idx == IW'(NSLICE - 1));

  assign bus.in_ready  = rstn && (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign busy          = (r_state != S_IDLE);
  assign add_a1        = r_add_a1;
  assign add_b1        = r_add_b1;
  assign add_a2        = r_add_a2;
  assign add_b2        = r_add_b2;
  assign add_cin       = r_add_cin;

  // Core inputs are loaded on the edge entering ISSUE, so they are live for exactly that cycle;
  // the add_cin register doubles as the running carry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_out_sum   <= '0;
      r_out_valid <= 1'b0;
      r_out_cout  <= 1'b0;
      r_idx       <= '0;
      r_wait      <= '0;
      r_add_a1    <= 1'b0;
      r_add_b1    <= 1'b0;
      r_add_a2    <= 1'b0;
      r_add_b2    <= 1'b0;
      r_add_cin   <= 1'b0;
    end else begin
      r_add_a1  <= 1'b0;
      r_add_b1  <= 1'b0;
      r_add_a2  <= 1'b0;
      r_add_b2  <= 1'b0;
      r_add_cin <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_a       <= bus.in_a;
          r_b       <= bus.in_b;
          r_idx     <= '0;
          r_add_a1  <= bus.in_a[0];
          r_add_b1  <= bus.in_b[0];
          r_add_a2  <= bus.in_a[1];
          r_add_b2  <= bus.in_b[1];
          r_add_cin <= bus.in_cin;
          r_state   <= S_ISSUE;
        end
        S_ISSUE: begin
          r_wait  <= WW'(ADD_LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WW'(1);
          end else begin
            r_sum <= w_sum_nxt;
            if (w_last) begin
              r_out_sum   <= w_sum_nxt;
              r_out_cout  <= add_cout;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_idx     <= w_idx_inc;
              r_add_a1  <= w_a_sh[0];
              r_add_b1  <= w_b_sh[0];
              r_add_a2  <= w_a_sh[1];
              r_add_b2  <= w_b_sh[1];
              r_add_cin <= add_cout;
              r_state   <= S_ISSUE;
            end
          end
        end
        S_DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FORMAL
  logic r_cin;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cin <= 1'b0;
    else if (r_state == S_IDLE && bus.in_valid) r_cin <= bus.in_cin;
  end

  a_add_idle: assert property (@(posedge clk) disable iff (!rstn)
    (r_state != S_ISSUE) |-> ({add_a1, add_b1, add_a2, add_b2, add_cin} == 5'b0));
  a_sum_ok: assert property (@(posedge clk) disable iff (!rstn)
    bus.out_valid |-> ({bus.out_cout, bus.out_sum} ==
                       ({1'b0, r_a} + {1'b0, r_b} + (WIDTH+1)'(r_cin))));
  a_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.in_ready && bus.out_valid));
`endif
endmodule

// File: tb/tb_bit2_adder_seq.sv
// Bench for bit2_adder_seq: 8-bit and 2-bit builds, each driving an arithmetic model of the 2-bit core.
module tb_bit2_adder_seq;
  localparam int LAT8 = 20;
  localparam int LAT2 = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit2_adder_seq_if #(.WIDTH(8)) bus();
  bit2_adder_seq_if #(.WIDTH(2)) bus2();

  logic a1, b1, a2, b2, ci, s1, s2, co, busy;
  logic a1_2, b1_2, a2_2, b2_2, ci_2, s1_2, s2_2, co_2, busy2;

  bit2_adder_seq #(.WIDTH(8), .ADD_LAT(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy),
    .add_a1(a1), .add_b1(b1), .add_a2(a2), .add_b2(b2), .add_cin(ci),
    .add_s1(s1), .add_s2(s2), .add_cout(co));

  bit2_adder_seq #(.WIDTH(2), .ADD_LAT(4)) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2), .busy(busy2),
    .add_a1(a1_2), .add_b1(b1_2), .add_a2(a2_2), .add_b2(b2_2), .add_cin(ci_2),
    .add_s1(s1_2), .add_s2(s2_2), .add_cout(co_2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 2-bit core: {cout,s2,s1} = {a2,a1} + {b2,b1} + cin, four register stages, shares rstn
  function automatic logic [2:0] core(input logic xa1, xb1, xa2, xb2, xc);
    return 3'({1'b0, xa2, xa1} + {1'b0, xb2, xb1} + {2'b0, xc});
  endfunction

  logic [3:0][2:0] cp, cp2;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cp  <= '0;
      cp2 <= '0;
    end else begin
      cp  <= {cp[2:0],  core(a1, b1, a2, b2, ci)};
      cp2 <= {cp2[2:0], core(a1_2, b1_2, a2_2, b2_2, ci_2)};
    end
  end
  assign {co, s2, s1}       = cp[3];
  assign {co_2, s2_2, s1_2} = cp2[3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard for the 8-bit build: expected sums queued at accept, compared every valid cycle.
  logic [8:0] exp_q[$];
  int         acc_cyc = 0;
  logic       prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({1'b0, bus.in_a} + {1'b0, bus.in_b} + {8'b0, bus.in_cin});
        acc_cyc = cyc + 1;
      end
      check("excl_ready_valid", 64'(bus.in_ready && bus.out_valid), 64'(0));
      if (bus.out_valid) begin
        if (!prev_ov) check("latency", 64'(cyc - acc_cyc), 64'(LAT8));
        check("add_idle_in_done", 64'({a1, b1, a2, b2, ci}), 64'(0));
        if (exp_q.size() == 0) check("spurious_result", 64'(1), 64'(0));
        else begin
          check("sum", 64'({bus.out_cout, bus.out_sum}), 64'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // Called and returns at #1 after a rising edge.
  task automatic do_op(input logic [7:0] a, b, input logic c, input bit rnd_rdy, input bit keep_v,
                       output int lat, output int nis, output logic [7:0] cseq, output int acc);
    int  k;
    logic hs;
    bus.in_a = a; bus.in_b = b; bus.in_cin = c; bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) check("accept_timeout", 64'(1), 64'(0));
    @(posedge clk); #1;
    acc = cyc;
    if (!keep_v) bus.in_valid = 1'b0;
    lat = 0; nis = 0; cseq = '0;
    while (!bus.out_valid && lat < 100) begin
      if (a1 | b1 | a2 | b2 | ci) begin cseq[nis % 8] = ci; nis++; end
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) check("result_timeout", 64'(1), 64'(0));
    if (rnd_rdy) begin
      k = 0;
      do begin
        bus.out_ready = ($urandom_range(0, 2) != 0);
        hs = bus.out_ready;
        @(posedge clk); #1; k++;
      end while (!hs && k < 50);
      bus.out_ready = 1'b1;
    end else if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op2(input logic [1:0] a, b, input logic c, output int lat);
    int k;
    bus2.in_a = a; bus2.in_b = b; bus2.in_cin = c; bus2.in_valid = 1'b1;
    k = 0;
    while (!bus2.in_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) check("accept2_timeout", 64'(1), 64'(0));
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    lat = 0;
    while (!bus2.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nis, acc;
    int accs[3];
    logic [7:0] cseq, cap_s, ra, rb;
    logic       cap_c, rc;

    bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.in_cin = 1'b0;  bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_cin = 1'b0; bus2.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_sum", 64'(bus.out_sum), 64'(0));
    check("rst_out_cout", 64'(bus.out_cout), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_add", 64'({a1, b1, a2, b2, ci}), 64'(0));
    check("rst_in_ready2", 64'(bus2.in_ready), 64'(0));
    rstn = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;

    // FF + 01: carry ripples through every slice
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat, nis, cseq, acc);
    check("t1_latency", 64'(lat), 64'(20));
    check("t1_issues", 64'(nis), 64'(4));
    check("t1_cin_seq", 64'(cseq[3:0]), 64'(4'b1110));
    check("t1_sum", 64'(bus.out_sum), 64'(8'h00));
    check("t1_cout", 64'(bus.out_cout), 64'(1));

    do_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, lat, nis, cseq, acc);
    check("t2a_sum", 64'({bus.out_cout, bus.out_sum}), 64'(9'h100));

    // backpressure on 12 + 34
    bus.out_ready = 1'b0;
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat, nis, cseq, acc);
    check("t2b_sum", 64'({bus.out_cout, bus.out_sum}), 64'(9'h046));
    cap_s = bus.out_sum; cap_c = bus.out_cout;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a = 8'($urandom);
      @(posedge clk); #1;
      check("bp_valid", 64'(bus.out_valid), 64'(1));
      check("bp_sum", 64'({bus.out_cout, bus.out_sum}), 64'({cap_c, cap_s}));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'(1));
    check("bp_release_valid", 64'(bus.out_valid), 64'(0));
    check("bp_hold_after", 64'(bus.out_sum), 64'(8'h46));

    // reset during the WAIT of slice 2
    bus.in_a = 8'h33; bus.in_b = 8'h44; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midop_busy_before", 64'(busy), 64'(1));
    rstn = 1'b0;
    #1;
    check("midop_busy", 64'(busy), 64'(0));
    check("midop_out_valid", 64'(bus.out_valid), 64'(0));
    check("midop_out_sum", 64'(bus.out_sum), 64'(0));
    check("midop_add", 64'({a1, b1, a2, b2, ci}), 64'(0));
    check("midop_in_ready", 64'(bus.in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("midop_release_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, lat, nis, cseq, acc);
    check("t4_latency", 64'(lat), 64'(20));
    check("t4_sum", 64'({bus.out_cout, bus.out_sum}), 64'(9'h010));

    // back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1, lat, nis, cseq, acc);
      accs[i] = acc;
    end
    bus.in_valid = 1'b0;
    check("b2b_space01", 64'(accs[1] - accs[0]), 64'(22));
    check("b2b_space12", 64'(accs[2] - accs[1]), 64'(22));

    // random operands, random gaps and random consumer stalls
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_op(ra, rb, rc, 1'b1, 1'b0, lat, nis, cseq, acc);
      check("rnd_latency", 64'(lat), 64'(20));
    end

    // 2-bit build: literal case then every input combination
    do_op2(2'b11, 2'b01, 1'b1, lat);
    check("w2_latency", 64'(lat), 64'(LAT2));
    check("w2_sum", 64'(bus2.out_sum), 64'(2'b01));
    check("w2_cout", 64'(bus2.out_cout), 64'(1));
    for (int v = 0; v < 32; v++) begin
      do_op2(2'(v), 2'(v >> 2), 1'(v >> 4), lat);
      check("w2_all_latency", 64'(lat), 64'(LAT2));
      check("w2_all_sum", 64'({bus2.out_cout, bus2.out_sum}),
            64'((v & 3) + ((v >> 2) & 3) + ((v >> 4) & 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bit2_adder_seq.md
Name: bit2_adder_seq

Overview:
Sequencer that performs WIDTH-bit additions on the shared 2-bit pipelined adder core (bit2_adder, 4-cycle latency). It accepts operands over a valid/ready handshake and issues 2-bit slices LSB-first. It feeds each slice's Cout back as the next slice's Cin, assembles the sum, and returns the result over a second valid/ready handshake. It sits between operand producers and the adder core instance, and drives all of the core's inputs.

Parameters:
WIDTH, 8, operand/sum width in bits; must be even and >= 2; NSLICE = WIDTH/2
ADD_LAT, 4, adder core latency in rising edges from input sampling edge to output valid

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
in_valid  input  1  operand request valid
in_ready  output  1  sequencer can accept operands
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry in for bit 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  sum bits
out_cout  output  1  carry out of MSB
busy  output  1  operation in progress (state != IDLE)
add_a1, add_b1, add_a2, add_b2, add_cin  output  1 each  drive the core's A1, B1, A2, B2, Cin
add_s1, add_s2, add_cout  input  1 each  from the core's S1, S2, Cout

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; out_valid=0; out_sum=0; out_cout=0; busy=0; all add_* outputs=0; in_ready=0 while rstn is low. The slice counter, wait counter and carry register clear to 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a, in_b and in_cin, set slice index i=0 and carry=in_cin, then go to ISSUE.
  - ISSUE: exactly one cycle. Drive add_a1=a[2i], add_b1=b[2i], add_a2=a[2i+1], add_b2=b[2i+1], add_cin=carry. Load the wait counter, then go to WAIT.
  - WAIT: ADD_LAT cycles; all add_* outputs are 0. In the final WAIT cycle, sample on the closing edge: sum[2i]=add_s1, sum[2i+1]=add_s2, carry=add_cout. If i==NSLICE-1, go to DONE; otherwise increment i and go to ISSUE.
  - DONE: out_valid=1, out_cout=carry. On out_ready, go to IDLE and drop out_valid.
- The add_* outputs are registered and are nonzero only in ISSUE. The core therefore samples each slice on the edge that ends the ISSUE cycle, and the result is present during the last WAIT cycle (ADD_LAT edges later).
- Each slice costs ADD_LAT+1 cycles.
- out_valid rises exactly (ADD_LAT+1)*NSLICE rising edges after the accepting edge: 20 for the defaults, 5 for WIDTH=2.
- out_sum and out_cout hold stable from the rise of out_valid until the handshake completes, and also afterwards until the next result overwrites them. Intermediate slice writes go to an internal register; out_sum updates only on entry to DONE.
- Backpressure: while in DONE with out_ready=0, the block holds indefinitely and in_ready=0. in_valid is ignored in every state except IDLE.
- Back-to-back: DONE+out_ready at edge k gives IDLE in cycle k+1. A new accept is possible at the end of that cycle, so minimum spacing between accepts is (ADD_LAT+1)*NSLICE+2 edges.
- Reset mid-operation: aborts immediately and returns to IDLE. The core shares rstn, so no stale slice result can be captured after release.
- Arithmetic: {out_cout,out_sum} == in_a + in_b + in_cin, computed modulo 2^(WIDTH+1) (no overflow possible).
- Formal (FORMAL ifdef): assert add_* == 0 outside ISSUE. Assert out_valid implies the arithmetic identity against the latched operands. Assert in_ready and out_valid are never both 1.

Test Plan:
1. WIDTH=8; in_a=8'hFF, in_b=8'h01, in_cin=0 -> out_sum=8'h00, out_cout=1. out_valid rises exactly 20 edges after the accept. Exactly 4 ISSUE cycles, with add_cin sequence 0,1,1,1.
2. in_a=8'hA5, in_b=8'h5A, in_cin=1 -> out_sum=8'h00, out_cout=1. in_a=8'h12, in_b=8'h34, in_cin=0 -> out_sum=8'h46, out_cout=0.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_sum and out_cout stay stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready -> IDLE next cycle and in_ready=1.
4. Reset mid-op: drop rstn during the WAIT of slice 2 -> all outputs go to 0 immediately and busy=0. After release, in_ready=1, and 8'h0F+8'h01+0 returns 8'h10, cout=0, with correct 20-edge latency.
5. Back-to-back: keep in_valid high with out_ready=1 across three random operand pairs -> three correct results, with accepts spaced exactly 22 edges apart.
6. WIDTH=2 build: 2'b11+2'b01, cin=1 -> out_sum=2'b01, out_cout=1, out_valid rising 5 edges after the accept.
